// File: rtl/spike_decoder_if.sv
// Handshake and result bundle between the spiking network readout and spike_decoder.
//   start      : one-cycle pulse; clears counters and begins a new inference
//   num_t      : timesteps per inference minus one, sampled on start
//   in_valid   : spike frame valid (network OUT_VALID)
//   in_spike   : spike frame, one bit per output neuron (network OUT_SPIKE)
//   busy       : decoder is accumulating or scanning
//   out_valid  : one-cycle pulse when out_class/out_max/out_tie are updated
//   out_class  : index of the neuron with the highest spike count
//   out_max    : spike count of the winning neuron
//   out_tie    : another neuron has a count equal to out_max
// master drives the frames (network / testbench); slave is the decoder.
interface spike_decoder_if #(
   parameter int unsigned IO_WIDTH  = 16,
   parameter int unsigned T_WIDTH   = 5,
   parameter int unsigned CNT_WIDTH = 6,
   parameter int unsigned CLS_WIDTH = 4
);
   logic                 start;
   logic [T_WIDTH-1:0]   num_t;
   logic                 in_valid;
   logic [IO_WIDTH-1:0]  in_spike;
   logic                 busy;
   logic                 out_valid;
   logic [CLS_WIDTH-1:0] out_class;
   logic [CNT_WIDTH-1:0] out_max;
   logic                 out_tie;

   modport master (
      output start, num_t, in_valid, in_spike,
      input  busy, out_valid, out_class, out_max, out_tie
   );

   modport slave (
      input  start, num_t, in_valid, in_spike,
      output busy, out_valid, out_class, out_max, out_tie
   );
endinterface

// File: rtl/spike_decoder.sv
// Rate-coded output decoder for the spiking network.
// Accumulates per-neuron spike counts over num_t+1 valid frames, then scans the counts one
// neuron per cycle to find the argmax (lowest index wins ties) and reports it for one cycle.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : spike_decoder_if slave (start/num_t/in_valid/in_spike in, busy/out_* out)
module spike_decoder #(
   parameter int unsigned IO_WIDTH  = 16,
   parameter int unsigned T_WIDTH   = 5,
   parameter int unsigned CNT_WIDTH = 6,
   parameter int unsigned CLS_WIDTH = 4
) (
   input logic            clk,
   input logic            rst_n,
   spike_decoder_if.slave bus
);

   localparam logic [CNT_WIDTH-1:0] CntMax  = {CNT_WIDTH{1'b1}};
   localparam logic [CLS_WIDTH-1:0] LastIdx = CLS_WIDTH'(IO_WIDTH - 1);

   typedef enum logic [1:0] {StIdle, StAcc, StScan, StDone} state_e;

   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q [IO_WIDTH];
   logic [CNT_WIDTH-1:0] cnt_acc [IO_WIDTH];
   logic [T_WIDTH-1:0]   frame_q;
   logic [T_WIDTH-1:0]   num_t_q;
   logic [CLS_WIDTH-1:0] scan_idx_q;
   logic [CNT_WIDTH-1:0] best_q, best_d;
   logic [CLS_WIDTH-1:0] best_idx_q, best_idx_d;
   logic                 tie_q, tie_d;
   logic [CLS_WIDTH-1:0] out_class_q;
   logic [CNT_WIDTH-1:0] out_max_q;
   logic                 out_tie_q;
   logic [CNT_WIDTH-1:0] scan_cnt;
   logic                 last_frame;
   logic                 scan_last;

   assign last_frame = bus.in_valid && (frame_q == num_t_q);
   assign scan_last  = (scan_idx_q == LastIdx);
   assign scan_cnt   = cnt_q[scan_idx_q];

   // ---------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM: next state. start overrides everything, including an in-flight scan.
   always_comb begin
      state_d = state_q;
      if (bus.start) begin
         state_d = StAcc;
      end else begin
         unique case (state_q)
            StIdle:  state_d = StIdle;
            StAcc:   if (last_frame) state_d = StScan;
            StScan:  if (scan_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      bus.busy      = (state_q == StAcc) || (state_q == StScan);
      bus.out_valid = (state_q == StDone);
   end

   // ---------------------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------------------
   // Saturating increment of every counter whose neuron fired in this frame.
   always_comb begin
      for (int i = 0; i < IO_WIDTH; i++) begin
         if (bus.in_spike[i] && (cnt_q[i] != CntMax)) begin
            cnt_acc[i] = cnt_q[i] + CNT_WIDTH'(1);
         end else begin
            cnt_acc[i] = cnt_q[i];
         end
      end
   end

   // One argmax step. Strict '>' keeps the earlier (lower) index on equal counts.
   always_comb begin
      best_d     = best_q;
      best_idx_d = best_idx_q;
      tie_d      = tie_q;
      if (scan_idx_q == '0) begin
         best_d     = scan_cnt;
         best_idx_d = '0;
         tie_d      = 1'b0;
      end else if (scan_cnt > best_q) begin
         best_d     = scan_cnt;
         best_idx_d = scan_idx_q;
         tie_d      = 1'b0;
      end else if (scan_cnt == best_q) begin
         tie_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < IO_WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         frame_q     <= '0;
         num_t_q     <= '0;
         scan_idx_q  <= '0;
         best_q      <= '0;
         best_idx_q  <= '0;
         tie_q       <= 1'b0;
         out_class_q <= '0;
         out_max_q   <= '0;
         out_tie_q   <= 1'b0;
      end else if (bus.start) begin
         // Frame arriving with start is dropped; previous results are left untouched.
         for (int i = 0; i < IO_WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         frame_q    <= '0;
         num_t_q    <= bus.num_t;
         scan_idx_q <= '0;
      end else begin
         unique case (state_q)
            StAcc: begin
               if (bus.in_valid) begin
                  cnt_q   <= cnt_acc;
                  frame_q <= frame_q + T_WIDTH'(1);
                  if (last_frame) begin
                     scan_idx_q <= '0;
                  end
               end
            end
            StScan: begin
               best_q     <= best_d;
               best_idx_q <= best_idx_d;
               tie_q      <= tie_d;
               scan_idx_q <= scan_last ? '0 : scan_idx_q + CLS_WIDTH'(1);
               // Capture the final step directly so the result is visible while out_valid is high.
               if (scan_last) begin
                  out_class_q <= best_idx_d;
                  out_max_q   <= best_d;
                  out_tie_q   <= tie_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.out_class = out_class_q;
   assign bus.out_max   = out_max_q;
   assign bus.out_tie   = out_tie_q;

endmodule
